// File: rtl/game_pkg.sv
// Shared constants and types for the frog/croc game.
// Used by game_ctrl, crocs and playsound so that all of them agree on the
// state encoding and on the widths of the lives and level buses.
package game_pkg;

  localparam int LIVES_W = 2;
  localparam int LEVEL_W = 3;

  // Game sequencer states. The numeric values are visible on the state port.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    DYING     = 3'd2,
    LEVEL_UP  = 3'd3,
    GAME_OVER = 3'd4
  } game_state_e;

  // Next level, saturating at max_lvl. The increment is one bit wider than
  // the level so that level 7 + 1 does not wrap to 0 before the compare.
  function automatic logic [LEVEL_W-1:0] next_level(
    input logic [LEVEL_W-1:0] lvl,
    input logic [LEVEL_W-1:0] max_lvl
  );
    logic [LEVEL_W:0] inc;
    inc = {1'b0, lvl} + {{LEVEL_W{1'b0}}, 1'b1};
    if (inc > {1'b0, max_lvl})
      return max_lvl;
    else
      return inc[LEVEL_W-1:0];
  endfunction

endpackage

// File: rtl/game_ctrl_hold_timer.sv
// hold_timer: counts tick pulses while the game is paused in DYING or
// LEVEL_UP and flags the tick that ends the pause.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   clear  in  hold the counter at 0 (asserted whenever no pause is running)
//   tick   in  frame enable pulse; advances the counter
//   done   out high on the tick where the counter sits at HOLD_TICKS-1
module hold_timer #(
  parameter int HOLD_TICKS = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic done
);

  localparam logic [7:0] LAST_CNT = 8'(HOLD_TICKS - 1);

  logic [7:0] cnt;

  // Clear dominates tick, so a pause always starts counting from 0 even if
  // a tick coincides with the transition into the pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= 8'd0;
    else if (clear)
      cnt <= 8'd0;
    else if (tick)
      cnt <= cnt + 8'd1;
  end

  assign done = (cnt == LAST_CNT) & tick;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: top-level game sequencer. Owns lives, level and the
// play/pause state; freezes motion, requests frog respawn and fires
// one-cycle sound requests.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   tick        frame/move enable pulse (drives the pause timer)
//   start       debounced start-button pulse
//   die         collision level from the collision checker
//   win         frog-reached-goal pulse
//   state       current FSM state (game_state_e encoding)
//   freeze      1 = frog and crocs hold position
//   respawn     one-cycle pulse: frog back to start position
//   lives       remaining lives
//   level       current level / croc speed multiplier
//   snd_die     one-cycle pulse to playsound die input
//   snd_win     one-cycle pulse to playsound win input
module game_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT = 3,
  parameter int MAX_LEVEL  = 7,
  parameter int HOLD_TICKS = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               start,
  input  logic               die,
  input  logic               win,
  output logic [2:0]         state,
  output logic               freeze,
  output logic               respawn,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level,
  output logic               snd_die,
  output logic               snd_win
);

  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);

  game_state_e st;
  logic        die_armed;
  logic        hold_clear;
  logic        hold_done;

  assign state      = st;
  assign hold_clear = !((st == DYING) || (st == LEVEL_UP));

  hold_timer #(
    .HOLD_TICKS(HOLD_TICKS)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (hold_clear),
    .tick  (tick),
    .done  (hold_done)
  );

  // Single sequencer block; every output is a register. Pulses default low
  // each cycle and are raised only on the edge of the transition that
  // requests them. die_armed stops a die level that is still high after a
  // respawn from costing a second life: it needs one PLAY cycle with die low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      freeze    <= 1'b1;
      respawn   <= 1'b0;
      lives     <= LIVES_LOAD;
      level     <= LEVEL_ONE;
      snd_die   <= 1'b0;
      snd_win   <= 1'b0;
      die_armed <= 1'b0;
    end else begin
      respawn <= 1'b0;
      snd_die <= 1'b0;
      snd_win <= 1'b0;
      case (st)
        IDLE, GAME_OVER: begin
          freeze <= 1'b1;
          if (start) begin
            st        <= PLAY;
            freeze    <= 1'b0;
            lives     <= LIVES_LOAD;
            level     <= LEVEL_ONE;
            respawn   <= 1'b1;
            die_armed <= 1'b0;
          end
        end
        PLAY: begin
          freeze <= 1'b0;
          if (die && die_armed && (lives != '0)) begin
            st        <= DYING;
            freeze    <= 1'b1;
            lives     <= lives - LIVES_W'(1);
            snd_die   <= 1'b1;
            die_armed <= 1'b0;
          end else begin
            if (!die)
              die_armed <= 1'b1;
            if (win) begin
              st      <= LEVEL_UP;
              freeze  <= 1'b1;
              level   <= next_level(level, LEVEL_MAX);
              snd_win <= 1'b1;
            end
          end
        end
        DYING: begin
          freeze <= 1'b1;
          if (hold_done) begin
            if (lives == '0) begin
              st <= GAME_OVER;
            end else begin
              st      <= PLAY;
              freeze  <= 1'b0;
              respawn <= 1'b1;
            end
          end
        end
        LEVEL_UP: begin
          freeze <= 1'b1;
          if (hold_done) begin
            st      <= PLAY;
            freeze  <= 1'b0;
            respawn <= 1'b1;
          end
        end
        default: begin
          st     <= IDLE;
          freeze <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: scoreboard bench for game_ctrl. Every change of the DUT
// output vector is one output event; the stimulus pushes the hand-computed
// sequence of output vectors it expects, and a monitor pops and compares
// one entry per observed change.
module tb_game_ctrl;
  import game_pkg::*;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       start;
  logic       die;
  logic       win;
  logic [2:0] state;
  logic       freeze;
  logic       respawn;
  logic [1:0] lives;
  logic [2:0] level;
  logic       snd_die;
  logic       snd_win;

  int  checks = 0;
  int  errors = 0;
  bit  tick_en;
  logic [11:0] exp_q[$];

  game_ctrl #(
    .LIVES_INIT(3),
    .MAX_LEVEL (7),
    .HOLD_TICKS(HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .start   (start),
    .die     (die),
    .win     (win),
    .state   (state),
    .freeze  (freeze),
    .respawn (respawn),
    .lives   (lives),
    .level   (level),
    .snd_die (snd_die),
    .snd_win (snd_win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout: state, freeze, lives, level, respawn, snd_die, snd_win.
  function automatic logic [11:0] vec(input logic [2:0] st, input logic fr,
                                      input logic [1:0] lv, input logic [2:0] lvl,
                                      input logic rs, input logic sd, input logic sw);
    return {st, fr, lv, lvl, rs, sd, sw};
  endfunction

  function automatic logic [11:0] out_now();
    return {state, freeze, lives, level, respawn, snd_die, snd_win};
  endfunction

  task automatic push(input logic [11:0] v);
    exp_q.push_back(v);
  endtask

  task automatic checkOutput(input logic [11:0] got);
    logic [11:0] expv;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_event: got st=%0d fr=%0d lv=%0d lvl=%0d rs=%0d sd=%0d sw=%0d, required no change",
               got[11:9], got[8], got[7:6], got[5:3], got[2], got[1], got[0]);
    end else begin
      expv = exp_q.pop_front();
      if (got !== expv) begin
        errors++;
        $display("[TB] FAIL event_%0d: got st=%0d fr=%0d lv=%0d lvl=%0d rs=%0d sd=%0d sw=%0d, required st=%0d fr=%0d lv=%0d lvl=%0d rs=%0d sd=%0d sw=%0d",
                 checks, got[11:9], got[8], got[7:6], got[5:3], got[2], got[1], got[0],
                 expv[11:9], expv[8], expv[7:6], expv[5:3], expv[2], expv[1], expv[0]);
      end
    end
  endtask

  // Drive start/die/win for n cycles, then return them low.
  task automatic applyStimulus(input logic s, input logic d, input logic w, input int n);
    @(posedge clk);
    #1;
    start = s;
    die   = d;
    win   = w;
    repeat (n) @(posedge clk);
    #1;
    start = 1'b0;
    die   = 1'b0;
    win   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic waitState(input logic [2:0] tgt, input int budget);
    int k;
    k = 0;
    while (state !== tgt && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (state !== tgt) begin
      errors++;
      $display("[TB] FAIL wait_state: state=%0d, required %0d within %0d cycles", state, tgt, budget);
    end
  endtask

  // Tick every 10 cycles, changed just after the rising edge.
  initial begin : tick_gen
    int tc;
    tc   = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tc   = (tc == 9) ? 0 : tc + 1;
      tick = tick_en && (tc == 9);
    end
  end

  // Monitor: one scoreboard comparison per observed change of the outputs.
  initial begin : monitor
    logic [11:0] prev;
    logic [11:0] cur;
    prev = 'x;
    forever begin
      @(negedge clk);
      cur = out_now();
      if (cur !== prev) begin
        checkOutput(cur);
        prev = cur;
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst_n   = 1'b1;
    start   = 1'b0;
    die     = 1'b0;
    win     = 1'b0;
    tick_en = 1'b1;

    // Reset values
    push(vec(IDLE, 1, 3, 1, 0, 0, 0));
    #2 rst_n = 1'b0;
    idle(2);
    #1 rst_n = 1'b1;
    idle(2);

    // win/die in IDLE are ignored
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 1, 0, 1);
    idle(2);

    // Start -> PLAY with full load and one respawn pulse
    push(vec(PLAY, 0, 3, 1, 1, 0, 0));
    push(vec(PLAY, 0, 3, 1, 0, 0, 0));
    applyStimulus(1, 0, 0, 1);
    idle(3);

    // start in PLAY is ignored
    applyStimulus(1, 0, 0, 1);
    idle(2);

    // die held high for 500 cycles costs exactly one life
    push(vec(DYING, 1, 2, 1, 0, 1, 0));
    push(vec(DYING, 1, 2, 1, 0, 0, 0));
    push(vec(PLAY,  0, 2, 1, 1, 0, 0));
    push(vec(PLAY,  0, 2, 1, 0, 0, 0));
    applyStimulus(0, 1, 0, 500);
    waitState(PLAY, 10);
    idle(3);

    // Separate deaths: lives 1, then 0 -> GAME_OVER
    push(vec(DYING, 1, 1, 1, 0, 1, 0));
    push(vec(DYING, 1, 1, 1, 0, 0, 0));
    push(vec(PLAY,  0, 1, 1, 1, 0, 0));
    push(vec(PLAY,  0, 1, 1, 0, 0, 0));
    applyStimulus(0, 1, 0, 1);
    waitState(PLAY, 100);
    idle(3);

    push(vec(DYING,     1, 0, 1, 0, 1, 0));
    push(vec(DYING,     1, 0, 1, 0, 0, 0));
    push(vec(GAME_OVER, 1, 0, 1, 0, 0, 0));
    applyStimulus(0, 1, 0, 1);
    waitState(GAME_OVER, 100);
    idle(3);

    // win in GAME_OVER is ignored; start reloads
    applyStimulus(0, 0, 1, 1);
    idle(2);
    push(vec(PLAY, 0, 3, 1, 1, 0, 0));
    push(vec(PLAY, 0, 3, 1, 0, 0, 0));
    applyStimulus(1, 0, 0, 1);
    idle(3);

    // Seven wins: level 2..7, then saturates at 7 with snd_win still firing
    for (int i = 1; i <= 7; i++) begin
      logic [2:0] lv;
      lv = (i + 1 > 7) ? 3'd7 : 3'(i + 1);
      push(vec(LEVEL_UP, 1, 3, lv, 0, 0, 1));
      push(vec(LEVEL_UP, 1, 3, lv, 0, 0, 0));
      push(vec(PLAY,     0, 3, lv, 1, 0, 0));
      push(vec(PLAY,     0, 3, lv, 0, 0, 0));
      applyStimulus(0, 0, 1, 1);
      waitState(PLAY, 100);
      idle(3);
    end

    // die and win together: die wins, level unchanged, no snd_win
    push(vec(DYING, 1, 2, 7, 0, 1, 0));
    push(vec(DYING, 1, 2, 7, 0, 0, 0));
    push(vec(PLAY,  0, 2, 7, 1, 0, 0));
    push(vec(PLAY,  0, 2, 7, 0, 0, 0));
    applyStimulus(0, 1, 1, 1);
    waitState(PLAY, 100);
    idle(3);

    // Reset pulse mid-DYING: straight back to reset values, no respawn
    push(vec(DYING, 1, 1, 7, 0, 1, 0));
    push(vec(DYING, 1, 1, 7, 0, 0, 0));
    push(vec(IDLE,  1, 3, 1, 0, 0, 0));
    applyStimulus(0, 1, 0, 1);
    idle(15);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(60);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_events: %0d expected events never seen, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
